rv32i_multicycle_ctrl: RTL and testbench
========================================

# rv32i_multicycle_ctrl

Multicycle control FSM for the RV32I core. It sequences one shared datapath (register file, ALU, immediate generator, PC/IR registers) and one unified memory port through fetch, decode, execute, memory and writeback. It decodes `instr[6:0]` and drives every datapath strobe and mux select, plus a req/ready handshake on the memory port. It replaces the single-cycle core's implicit sequencing so instruction and data can share one memory.

## Interface

**Parameters**
- none. Opcode and select encodings come from the shared package.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: IR contents, valid from DECODE onward.
- `br_taken` in 1: ALU compare result; valid in EXEC of a branch.
- `mem_ready` in 1: memory has completed the current request.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write (store).
- `mem_addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result register.
- `ir_we` out 1: load IR from memory read data and copy PC into `old_pc`.
- `pc_we` out 1: load PC.
- `pc_src` out 2: PC source. 0 = PC+4, 1 = `old_pc`+imm, 2 = ALU result with bit0 cleared.
- `alu_src_a` out 2: ALU operand A. 0 = rs1, 1 = `old_pc`, 2 = zero.
- `alu_src_b` out 1: ALU operand B. 0 = rs2, 1 = imm.
- `alu_op` out 2: ALU operation. 0 = add, 1 = funct3/funct7 decoded, 2 = branch compare.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: writeback source. 0 = ALU result, 1 = memory read data, 2 = `old_pc`+4.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `halted` out 1: FSM is in HALT.
- `state_o` out 3: current state, for debug.

## Operation

**States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore: decoded from state and the latched opcode.

- **IDLE** (reset state): all outputs 0. Next state is FETCH, unconditionally.
- **FETCH:** `mem_req`=1, `mem_addr_sel`=0.
  - While `mem_ready`=0: hold; `ir_we` and `pc_we` stay 0.
  - When `mem_ready`=1: assert `ir_we`, `pc_we`, `pc_src`=0; go to DECODE.
- **DECODE:** classify the opcode.
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP → EXEC.
  - FENCE (0001111) → FETCH, treated as a NOP.
  - SYSTEM (1110011) → HALT, with `illegal`=0.
  - Any other opcode → `illegal`=1 for this cycle, then HALT.
- **EXEC:** ALU setup per class.
  - OP: A=rs1, B=rs2, op=1.
  - OP-IMM: A=rs1, B=imm, op=1.
  - LOAD/STORE/JALR: A=rs1, B=imm, op=0.
  - LUI: A=zero, B=imm, op=0.
  - AUIPC: A=`old_pc`, B=imm, op=0.
  - JAL: no ALU use.
  - BRANCH: A=rs1, B=rs2, op=2; `pc_we`=`br_taken`, `pc_src`=1; next state FETCH.
  - Next state: MEM for LOAD/STORE, otherwise WB.
- **MEM:** `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE.
  - Hold until `mem_ready`=1.
  - Then LOAD → WB; STORE → FETCH.
- **WB:** `reg_we`=1.
  - `wb_sel`=1 for LOAD, 2 for JAL/JALR, 0 for all others.
  - JAL additionally asserts `pc_we` with `pc_src`=1; JALR asserts `pc_we` with `pc_src`=2.
  - Next state FETCH.
- **HALT:** all strobes 0, `halted`=1. Only `rst` leaves this state.

## Timing

- **Reset values:** while `rst` is asserted, state=IDLE and every output is 0, including `mem_req`. Outputs drop asynchronously when `rst` rises.
- **Reset mid-operation:** any outstanding memory request is abandoned, and no write strobe fires afterwards. After `rst` falls, there is one IDLE cycle, then FETCH.
- **Handshake:**
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable from assertion until the cycle in which `mem_ready`=1. The transfer completes on that rising edge.
  - `mem_ready` is ignored while `mem_req`=0.
  - `mem_ready` held permanently high means zero wait states.
- **Latency, zero wait states:**
  - BRANCH: 3 cycles.
  - STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - FENCE: 2 cycles.
  - Each wait cycle adds 1 cycle in FETCH or MEM.
- **Write exclusivity:** `reg_we` is high in WB only. `pc_we` and `ir_we` never assert outside the cases listed above.
- **Write ordering:** a JAL/JALR register write and PC write share the same edge. Correct ordering is guaranteed because writeback uses `old_pc`, not PC.

## Structure

- **Package `rv32i_pkg`:**
  - Opcode constants, shared with the immediate generator.
  - State enum encoding (3 bits, IDLE=0).
  - `pc_src`, `alu_src_a`, `wb_sel` and `alu_op` encodings.
- **Sub-module `rv32i_opclass`:** combinational; opcode in, one-hot class plus legal flag out. Instantiated once inside the FSM.
- The FSM is one state register plus next-state logic and output decode.

## Test plan

- **`addi x1,x0,5` (0x00500093), `mem_ready` tied high** → states FETCH, DECODE, EXEC, WB. `reg_we`=1 only in WB, with `wb_sel`=0, `alu_src_b`=1, `alu_op`=1.
- **`lw x2,0(x1)` (0x0000A103), `mem_ready` low 2 cycles in MEM** → stays in MEM for 3 cycles with `mem_addr_sel`=1 and `mem_we`=0. Then WB with `wb_sel`=1; total 7 cycles.
- **`beq x0,x0,8` (0x00000463)** → with `br_taken`=1, `pc_we`=1 and `pc_src`=1 in EXEC, then FETCH. With `br_taken`=0, `pc_we`=0 in EXEC. Both cases take 3 cycles.
- **`jal x1,16` (0x010000EF)** → in WB, `reg_we`=1, `wb_sel`=2, `pc_we`=1 and `pc_src`=1 on the same cycle.
- **0xFFFFFFFF** → `illegal`=1 for exactly one cycle, then `halted`=1, with no `mem_req` for 100 cycles. After a `rst` pulse: IDLE, then FETCH.
- **`rst` asserted mid-FETCH while `mem_req`=1** → `mem_req`=0 in the same cycle. `sw` (0x0020A023) in MEM with `rst` → `mem_we` drops immediately and no write completes.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, control FSM states and datapath mux selects.
// Used by the control FSM, its opcode classifier and the immediate generator.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_REL    = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] ASRC_RS1   = 2'd0;
  localparam logic [1:0] ASRC_OLDPC = 2'd1;
  localparam logic [1:0] ASRC_ZERO  = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd1;
  localparam logic [1:0] ALU_CMP   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic opimm;
    logic op_reg;
    logic fence;
    logic system;
  } opclass_t;

endpackage

// File: rtl/rv32i_opclass.sv
// Opcode classifier: one-hot instruction class plus a legal flag.
module rv32i_opclass
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls,
  output logic       legal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_OPIMM:  cls.opimm  = 1'b1;
      OPC_OP:     cls.op_reg = 1'b1;
      OPC_FENCE:  cls.fence  = 1'b1;
      OPC_SYSTEM: cls.system = 1'b1;
      default:    cls        = '0;
    endcase
    legal = (cls != '0);
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over
// one shared datapath and a single req/ready memory port.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state_o
);

  state_t   state, nxt;
  opclass_t cls;
  logic     legal;

  // Register and funct fields are consumed by the datapath; sequencing needs only the opcode.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr[31:7];

  rv32i_opclass u_opclass (
    .opcode (instr[6:0]),
    .cls    (cls),
    .legal  (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  assign state_o = state;

  always_comb begin
    nxt          = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_a    = ASRC_RS1;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = 1'b0;
    halted       = 1'b0;

    case (state)
      S_IDLE: nxt = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = PC_PLUS4;
          nxt    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cls.fence)       nxt = S_FETCH;
        else if (cls.system) nxt = S_HALT;
        else if (!legal) begin
          illegal = 1'b1;
          nxt     = S_HALT;
        end else             nxt = S_EXEC;
      end

      S_EXEC: begin
        nxt = (cls.load || cls.store) ? S_MEM : S_WB;
        if (cls.op_reg) begin
          alu_op = ALU_FUNCT;
        end
        if (cls.opimm) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        if (cls.load || cls.store || cls.jalr) alu_src_b = 1'b1;
        if (cls.lui) begin
          alu_src_a = ASRC_ZERO;
          alu_src_b = 1'b1;
        end
        if (cls.auipc) begin
          alu_src_a = ASRC_OLDPC;
          alu_src_b = 1'b1;
        end
        // Branch target is old_pc+imm; the ALU is busy with the compare.
        if (cls.branch) begin
          alu_op = ALU_CMP;
          pc_we  = br_taken;
          pc_src = PC_REL;
          nxt    = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        if (mem_ready) nxt = cls.load ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_we = 1'b1;
        if (cls.load)                wb_sel = WB_MEM;
        else if (cls.jal || cls.jalr) wb_sel = WB_LINK;
        if (cls.jal) begin
          pc_we  = 1'b1;
          pc_src = PC_REL;
        end
        if (cls.jalr) begin
          pc_we  = 1'b1;
          pc_src = PC_ALU;
        end
        nxt = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: per-instruction phase-string model with
// random wait states, random opcodes and random mid-instruction resets.
module tb_rv32i_multicycle_ctrl;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_src_b, reg_we, illegal, halted;
  logic [1:0]  pc_src, alu_src_a, alu_op, wb_sel;
  logic [2:0]  state_o;

  rv32i_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal),
    .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Bit map: 19 mem_req, 18 mem_we, 17 mem_addr_sel, 16 ir_we, 15 pc_we, 14:13 pc_src,
  // 12:11 alu_src_a, 10 alu_src_b, 9:8 alu_op, 7 reg_we, 6:5 wb_sel, 4 illegal, 3 halted, 2:0 state
  wire [19:0] dut_v = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_a,
                       alu_src_b, alu_op, reg_we, wb_sel, illegal, halted, state_o};

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] trace[$];
  logic [19:0] last_pre, last_post;

  function automatic bit legal_opc(logic [6:0] o);
    case (o)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Phase sequence of one instruction: F=fetch D=decode E=exec M=mem W=writeback H=halt
  function automatic string seq_of(logic [6:0] o);
    case (o)
      7'b0000011: return "FDEMW";
      7'b0100011: return "FDEM";
      7'b1100011: return "FDE";
      7'b0001111: return "FD";
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011: return "FDEW";
      default: return "FDH";
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(byte ph, logic [6:0] o, bit rdy, bit tk);
    logic mreq, mwe, masel, irwe, pcwe, asb, regwe, ill, hlt;
    logic [1:0] pcs, asa, aop, wbs;
    logic [2:0] stv;
    bit ld, st, br, jal, jalr, lui, aui, opi, opr;
    ld = (o == 7'b0000011); st = (o == 7'b0100011); br = (o == 7'b1100011);
    jal = (o == 7'b1101111); jalr = (o == 7'b1100111); lui = (o == 7'b0110111);
    aui = (o == 7'b0010111); opi = (o == 7'b0010011); opr = (o == 7'b0110011);
    {mreq, mwe, masel, irwe, pcwe, asb, regwe, ill, hlt} = '0;
    {pcs, asa, aop, wbs} = '0;
    stv = 3'd0;
    case (ph)
      "F": begin mreq = 1; irwe = rdy; pcwe = rdy; stv = S_FETCH; end
      "D": begin ill = !legal_opc(o); stv = S_DECODE; end
      "E": begin
        stv = S_EXEC;
        if (opr) {asa, asb, aop} = {2'd0, 1'b0, 2'd1};
        if (opi) {asa, asb, aop} = {2'd0, 1'b1, 2'd1};
        if (ld || st || jalr) {asa, asb, aop} = {2'd0, 1'b1, 2'd0};
        if (lui) {asa, asb, aop} = {2'd2, 1'b1, 2'd0};
        if (aui) {asa, asb, aop} = {2'd1, 1'b1, 2'd0};
        if (br) begin {asa, asb, aop} = {2'd0, 1'b0, 2'd2}; pcwe = tk; pcs = 2'd1; end
      end
      "M": begin mreq = 1; masel = 1; mwe = st; stv = S_MEM; end
      "W": begin
        stv = S_WB; regwe = 1;
        wbs = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        if (jal)  begin pcwe = 1; pcs = 2'd1; end
        if (jalr) begin pcwe = 1; pcs = 2'd2; end
      end
      "H": begin hlt = 1; stv = S_HALT; end
      default: stv = 3'd0;
    endcase
    return {mreq, mwe, masel, irwe, pcwe, pcs, asa, asb, aop, regwe, wbs, ill, hlt, stv};
  endfunction

  task automatic chk(string nm, logic [19:0] exp);
    n_vec++;
    if (dut_v !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, dut_v, exp, $time);
    end
  endtask

  task automatic lit(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int count_bit(int b);
    int n;
    logic [19:0] t;
    n = 0;
    foreach (trace[i]) begin
      t = trace[i];
      n += int'(t[b]);
    end
    return n;
  endfunction

  // Called with rst already high; ends just after the edge that enters FETCH.
  task automatic finish_reset();
    @(posedge clk); #1;
    chk("rst_hold", 20'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_after_rst", exp_vec("I", 7'h0, 1'b0, 1'b0));
    @(posedge clk); #1;
  endtask

  // Entered and left just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit tk,
                           input byte rph, input int hcyc, output int cyc, output bit stopped);
    string s;
    int k, fl, ml;
    bit rdy, load_ir;
    byte ph;
    s = seq_of(ins[6:0]);
    k = 0; fl = fw; ml = mw; load_ir = 0;
    cyc = 0; stopped = 0;
    trace.delete();
    while (k < s.len()) begin
      ph = s[k];
      if (ph == "H") begin
        for (int h = 0; h < hcyc; h++) begin
          mem_ready = 1'($urandom); br_taken = 1'($urandom);
          @(negedge clk);
          chk("halt", exp_vec("H", ins[6:0], mem_ready, br_taken));
          trace.push_back(dut_v); cyc++;
          @(posedge clk); #1;
        end
        stopped = 1;
        return;
      end
      if (ph == "F")      rdy = (fl == 0);
      else if (ph == "M") rdy = (ml == 0);
      else                rdy = 1'($urandom);
      mem_ready = rdy;
      br_taken  = (ph == "E") ? tk : 1'($urandom);
      if (ph == rph) begin
        #1;
        chk("pre_rst", exp_vec(ph, ins[6:0], rdy, br_taken));
        last_pre = dut_v;
        rst = 1'b1; #1;
        last_post = dut_v;
        chk("rst_async", 20'h0);
        stopped = 1;
        return;
      end
      @(negedge clk);
      chk({"phase_", string'(ph)}, exp_vec(ph, ins[6:0], rdy, br_taken));
      trace.push_back(dut_v); cyc++;
      if (ph == "F") begin
        if (rdy) begin k++; load_ir = 1; end else fl--;
      end else if (ph == "M") begin
        if (rdy) k++; else ml--;
      end else k++;
      @(posedge clk); #1;
      if (load_ir) begin instr = ins; load_ir = 0; end
    end
  endtask

  initial begin
    int cyc, r, fw, mw, hc, idx;
    bit stp, tk;
    logic [19:0] v;
    logic [31:0] tmp, ins;
    logic [6:0] opc;
    logic [6:0] ops[10];
    string phs;
    byte rph;

    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
    phs = "FDEMW";
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; br_taken = 1'b0;
    #2;
    chk("reset_state", 20'h0);
    finish_reset();

    run_instr(32'h00500093, 0, 0, 0, "x", 0, cyc, stp);
    lit("addi_cycles", cyc, 4);
    v = trace[2];
    lit("addi_exec_srcb", int'(v[10]), 1);
    lit("addi_exec_aluop", int'(v[9:8]), 1);
    v = trace[3];
    lit("addi_wb_regwe", int'(v[7]), 1);
    lit("addi_wb_sel", int'(v[6:5]), 0);
    lit("addi_regwe_count", count_bit(7), 1);

    run_instr(32'h0000A103, 0, 2, 0, "x", 0, cyc, stp);
    lit("lw_cycles", cyc, 7);
    lit("lw_addrsel_count", count_bit(17), 3);
    lit("lw_memwe_count", count_bit(18), 0);
    v = trace[6];
    lit("lw_wb_sel", int'(v[6:5]), 1);

    run_instr(32'h00000463, 0, 0, 1, "x", 0, cyc, stp);
    lit("beq_t_cycles", cyc, 3);
    v = trace[2];
    lit("beq_t_pcwe", int'(v[15]), 1);
    lit("beq_t_pcsrc", int'(v[14:13]), 1);
    run_instr(32'h00000463, 0, 0, 0, "x", 0, cyc, stp);
    lit("beq_nt_cycles", cyc, 3);
    v = trace[2];
    lit("beq_nt_pcwe", int'(v[15]), 0);

    run_instr(32'h010000EF, 0, 0, 0, "x", 0, cyc, stp);
    lit("jal_cycles", cyc, 4);
    v = trace[3];
    lit("jal_wb_regwe", int'(v[7]), 1);
    lit("jal_wb_sel", int'(v[6:5]), 2);
    lit("jal_wb_pcwe", int'(v[15]), 1);
    lit("jal_wb_pcsrc", int'(v[14:13]), 1);

    run_instr(32'h0000000F, 0, 0, 0, "x", 0, cyc, stp);
    lit("fence_cycles", cyc, 2);

    run_instr(32'h00500093, 3, 0, 0, "F", 0, cyc, stp);
    lit("fetch_rst_req_pre", int'(last_pre[19]), 1);
    lit("fetch_rst_req_post", int'(last_post[19]), 0);
    finish_reset();

    run_instr(32'h0020A023, 0, 3, 0, "M", 0, cyc, stp);
    lit("sw_rst_we_pre", int'(last_pre[18]), 1);
    lit("sw_rst_we_post", int'(last_post[18]), 0);
    finish_reset();

    run_instr(32'hFFFFFFFF, 0, 0, 0, "x", 100, cyc, stp);
    lit("illegal_pulses", count_bit(4), 1);
    lit("illegal_memreq_count", count_bit(19), 1);
    lit("illegal_halted_count", count_bit(3), 100);
    rst = 1'b1; #1;
    chk("rst_async", 20'h0);
    finish_reset();

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) opc = 7'b1110011;
      else if (r < 6) begin
        opc = 7'h7F;
        for (int t = 0; t < 50; t++) begin
          opc = 7'($urandom);
          if (!legal_opc(opc)) break;
        end
        if (legal_opc(opc)) opc = 7'h7F;
      end else opc = ops[$urandom_range(0, 9)];
      tmp = $urandom();
      ins = {tmp[31:7], opc};
      fw  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
      mw  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
      tk  = 1'($urandom);
      idx = $urandom_range(0, 4);
      rph = ($urandom_range(0, 19) == 0) ? phs[idx] : "x";
      hc  = $urandom_range(2, 6);
      run_instr(ins, fw, mw, tk, rph, hc, cyc, stp);
      if (stp) begin
        if (!rst) begin
          rst = 1'b1; #1;
          chk("rst_async", 20'h0);
        end
        finish_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
